// File: rtl/prog_word_loader.sv
// Byte-to-word program loader: packs a UART byte stream into memory words and
// writes them to consecutive addresses, otherwise passing the CPU port through.
module prog_word_loader #(
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_W         = 10,
  parameter bit BIG_ENDIAN     = 1'b0
) (
  input  logic                        clkMem,
  input  logic                        rstn,
  input  logic [7:0]                  progData,
  input  logic                        progValid,
  input  logic                        progEn,
  input  logic [ADDR_W-1:0]           addrIn,
  input  logic [8*BYTES_PER_WORD-1:0] dataIn,
  input  logic [BYTES_PER_WORD-1:0]   weIn,
  input  logic                        enIn,
  output logic [ADDR_W-1:0]           addrOut,
  output logic [8*BYTES_PER_WORD-1:0] dataOut,
  output logic [BYTES_PER_WORD-1:0]   weOut,
  output logic                        enOut,
  output logic                        progBusy,
  output logic                        progDone,
  output logic [ADDR_W:0]             wordCount,
  output logic                        overflow
);

  localparam int W     = 8 * BYTES_PER_WORD;
  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FLUSH} state_t;

  state_t                state, stateNext;
  logic                  progEnQ, validQ;
  logic [IDX_W-1:0]      byteIdx, byteIdxNext;
  logic [W-1:0]          asmWord, asmNext;
  logic [W-1:0]          wreg, wregNext;
  logic [BYTES_PER_WORD-1:0] wbe, wbeNext;
  logic [ADDR_W-1:0]     wordAddr, wordAddrNext;
  logic [ADDR_W:0]       wordCountNext;
  logic                  overflowNext;
  logic                  doneNext;
  logic                  accept;
  logic                  passThru;
  logic                  writeCyc;

  function automatic int laneOf(input int k);
    return BIG_ENDIAN ? (BYTES_PER_WORD - 1 - k) : k;
  endfunction

  function automatic logic [W-1:0] mergeByte(input logic [W-1:0] word,
                                             input logic [7:0] b,
                                             input logic [IDX_W-1:0] k);
    int sh;
    sh = 8 * laneOf(int'(k));
    return (word & ~(W'(8'hFF) << sh)) | (W'(b) << sh);
  endfunction

  function automatic logic [BYTES_PER_WORD-1:0] filledLanes(input logic [IDX_W-1:0] n);
    logic [BYTES_PER_WORD-1:0] be;
    be = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (i < int'(n)) be = be | (BYTES_PER_WORD'(1) << laneOf(i));
    end
    return be;
  endfunction

  // Strobe edge detection: one byte per rising edge of progValid, and never
  // in the cycle where progEn itself rises.
  assign accept = progValid & ~validQ & progEn & progEnQ &
                  ((state == COLLECT) || (state == WRITE));

  always_comb begin
    stateNext     = state;
    byteIdxNext   = byteIdx;
    asmNext       = asmWord;
    wregNext      = wreg;
    wbeNext       = wbe;
    wordAddrNext  = wordAddr;
    wordCountNext = wordCount;
    overflowNext  = overflow;
    doneNext      = 1'b0;

    if (accept) begin
      if (byteIdx == LAST_IDX) begin
        wregNext    = mergeByte(asmWord, progData, byteIdx);
        wbeNext     = '1;
        byteIdxNext = '0;
        asmNext     = '0;
      end else begin
        asmNext     = mergeByte(asmWord, progData, byteIdx);
        byteIdxNext = byteIdx + 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (progEn && !progEnQ) begin
          stateNext     = COLLECT;
          wordAddrNext  = '0;
          byteIdxNext   = '0;
          asmNext       = '0;
          wordCountNext = '0;
          overflowNext  = 1'b0;
        end
      end
      COLLECT: begin
        if (accept && (byteIdx == LAST_IDX)) begin
          stateNext = WRITE;
        end else if (!progEn) begin
          if (byteIdx != '0) begin
            stateNext = FLUSH;
            wregNext  = asmWord;
            wbeNext   = filledLanes(byteIdx);
          end else begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end
        end
      end
      WRITE, FLUSH: begin
        wordAddrNext  = wordAddr + 1'b1;
        wordCountNext = wordCount + 1'b1;
        if (wordAddr == '1) overflowNext = 1'b1;
        if (state == FLUSH) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end else if (progEn) begin
          stateNext = COLLECT;
        end else if (byteIdx != '0) begin
          stateNext = FLUSH;
          wregNext  = asmWord;
          wbeNext   = filledLanes(byteIdx);
        end else begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clkMem or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      progEnQ   <= 1'b0;
      validQ    <= 1'b0;
      byteIdx   <= '0;
      asmWord   <= '0;
      wreg      <= '0;
      wbe       <= '0;
      wordAddr  <= '0;
      wordCount <= '0;
      overflow  <= 1'b0;
      progDone  <= 1'b0;
    end else begin
      state     <= stateNext;
      progEnQ   <= progEn;
      validQ    <= progValid;
      byteIdx   <= byteIdxNext;
      asmWord   <= asmNext;
      wreg      <= wregNext;
      wbe       <= wbeNext;
      wordAddr  <= wordAddrNext;
      wordCount <= wordCountNext;
      overflow  <= overflowNext;
      progDone  <= doneNext;
    end
  end

  // Port ownership: the CPU keeps the port only while idle with programming off.
  assign passThru = (state == IDLE) && !progEn;
  assign writeCyc = (state == WRITE) || (state == FLUSH);

  always_comb begin
    addrOut  = wordAddr;
    dataOut  = wreg;
    weOut    = '0;
    enOut    = 1'b0;
    progBusy = rstn & ~passThru;
    if (passThru) begin
      addrOut = addrIn;
      dataOut = dataIn;
      weOut   = weIn;
      enOut   = enIn;
    end else if (writeCyc) begin
      weOut = wbe;
      enOut = 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_word_loader.sv
// Scoreboard bench for prog_word_loader: a little-endian 10-bit-address
// instance and a big-endian 2-bit-address instance share one byte stream.
`timescale 1ns/1ps
module tb_prog_word_loader;
  localparam int BPW = 4;
  localparam int W   = 8 * BPW;
  localparam int AWA = 10;
  localparam int AWB = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [7:0] progData = 8'h00;
  logic progValid = 1'b0;
  logic progEn = 1'b0;
  logic [AWA-1:0] addrIn = '0;
  logic [W-1:0] dataIn = '0;
  logic [BPW-1:0] weIn = '0;
  logic enIn = 1'b0;
  logic [AWB-1:0] addrInB;

  logic [AWA-1:0] addrOutA; logic [W-1:0] dataOutA; logic [BPW-1:0] weOutA;
  logic enOutA, progBusyA, progDoneA, overflowA; logic [AWA:0] wordCountA;
  logic [AWB-1:0] addrOutB; logic [W-1:0] dataOutB; logic [BPW-1:0] weOutB;
  logic enOutB, progBusyB, progDoneB, overflowB; logic [AWB:0] wordCountB;

  assign addrInB = addrIn[AWB-1:0];

  prog_word_loader #(.BYTES_PER_WORD(BPW), .ADDR_W(AWA), .BIG_ENDIAN(1'b0)) dutA (
    .clkMem(clk), .rstn(rstn), .progData(progData), .progValid(progValid), .progEn(progEn),
    .addrIn(addrIn), .dataIn(dataIn), .weIn(weIn), .enIn(enIn),
    .addrOut(addrOutA), .dataOut(dataOutA), .weOut(weOutA), .enOut(enOutA),
    .progBusy(progBusyA), .progDone(progDoneA), .wordCount(wordCountA), .overflow(overflowA));

  prog_word_loader #(.BYTES_PER_WORD(BPW), .ADDR_W(AWB), .BIG_ENDIAN(1'b1)) dutB (
    .clkMem(clk), .rstn(rstn), .progData(progData), .progValid(progValid), .progEn(progEn),
    .addrIn(addrInB), .dataIn(dataIn), .weIn(weIn), .enIn(enIn),
    .addrOut(addrOutB), .dataOut(dataOutB), .weOut(weOutB), .enOut(enOutB),
    .progBusy(progBusyB), .progDone(progDoneB), .wordCount(wordCountB), .overflow(overflowB));

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    logic [W-1:0] data;
    logic [BPW-1:0] we;
  } wr_t;

  wr_t qA[$];
  wr_t qB[$];
  wr_t eA, eB;
  logic [7:0] curBytes[$];
  int sessWords = 0;
  int doneExp = 0;
  int doneA = 0;
  int doneB = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference packing straight from the byte-order rule.
  function automatic logic [W-1:0] pack(input logic [7:0] bs[$], input bit be);
    logic [W-1:0] d = '0;
    for (int k = 0; k < bs.size(); k++)
      d = d | (W'(bs[k]) << (8 * (be ? (BPW - 1 - k) : k)));
    return d;
  endfunction

  function automatic logic [BPW-1:0] lanes(input int n, input bit be);
    logic [BPW-1:0] m = '0;
    for (int k = 0; k < n; k++) m = m | (BPW'(1) << (be ? (BPW - 1 - k) : k));
    return m;
  endfunction

  task automatic pushWord();
    wr_t e;
    e.addr = sessWords % (1 << AWA);
    e.data = pack(curBytes, 1'b0);
    e.we   = lanes(curBytes.size(), 1'b0);
    qA.push_back(e);
    e.addr = sessWords % (1 << AWB);
    e.data = pack(curBytes, 1'b1);
    e.we   = lanes(curBytes.size(), 1'b1);
    qB.push_back(e);
    sessWords++;
    curBytes.delete();
  endtask

  task automatic modelByte(input logic [7:0] b);
    curBytes.push_back(b);
    if (curBytes.size() == BPW) pushWord();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    addrIn = AWA'($urandom);
    dataIn = $urandom;
    weIn   = BPW'($urandom);
    enIn   = 1'($urandom);
  endtask

  task automatic checkCounters();
    chk("wordCountA", 64'(wordCountA), 64'(sessWords % (1 << (AWA + 1))));
    chk("wordCountB", 64'(wordCountB), 64'(sessWords % (1 << (AWB + 1))));
    chk("overflowA", 64'(overflowA), 64'(sessWords >= (1 << AWA)));
    chk("overflowB", 64'(overflowB), 64'(sessWords >= (1 << AWB)));
  endtask

  task automatic startSession();
    progEn = 1'b1;
    tick();
    sessWords = 0;
    curBytes.delete();
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    modelByte(b);
    progData  = b;
    progValid = 1'b1;
    tick();
    progValid = 1'b0;
    tick();
    repeat (gap) tick();
    checkCounters();
  endtask

  task automatic endSession();
    if (curBytes.size() > 0) pushWord();
    progEn = 1'b0;
    repeat (3) tick();
    doneExp++;
    chk("doneCountA", 64'(doneA), 64'(doneExp));
    chk("doneCountB", 64'(doneB), 64'(doneExp));
    chk("busyAfterA", 64'(progBusyA), 64'd0);
    checkCounters();
  endtask

  // Monitor: pops one expectation per programming write; otherwise checks
  // pass-through or a quiet port.
  always @(negedge clk) begin
    if (rstn) begin
      if (progDoneA) doneA++;
      if (progDoneB) doneB++;
      if (!progBusyA)
        chk("mirrorA", 64'({addrOutA, dataOutA, weOutA, enOutA}), 64'({addrIn, dataIn, weIn, enIn}));
      else if (enOutA) begin
        if (qA.size() == 0) chk("unexpectedWriteA", 64'(enOutA), 64'd0);
        else begin
          eA = qA.pop_front();
          chk("addrA", 64'(addrOutA), 64'(eA.addr));
          chk("dataA", 64'(dataOutA), 64'(eA.data));
          chk("weA", 64'(weOutA), 64'(eA.we));
        end
      end else chk("quietWeA", 64'(weOutA), 64'd0);
      if (!progBusyB)
        chk("mirrorB", 64'({addrOutB, dataOutB, weOutB, enOutB}), 64'({addrInB, dataIn, weIn, enIn}));
      else if (enOutB) begin
        if (qB.size() == 0) chk("unexpectedWriteB", 64'(enOutB), 64'd0);
        else begin
          eB = qB.pop_front();
          chk("addrB", 64'(addrOutB), 64'(eB.addr));
          chk("dataB", 64'(dataOutB), 64'(eB.data));
          chk("weB", 64'(weOutB), 64'(eB.we));
        end
      end else chk("quietWeB", 64'(weOutB), 64'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    repeat (3) tick();
    chk("rstBusyA", 64'(progBusyA), 64'd0);
    chk("rstDoneA", 64'(progDoneA), 64'd0);
    chk("rstCountA", 64'(wordCountA), 64'd0);
    chk("rstOvfB", 64'(overflowB), 64'd0);
    rstn = 1'b1;
    tick();

    // CPU pass-through
    addrIn = 10'h155; dataIn = 32'hDEADBEEF; weIn = 4'hF; enIn = 1'b1;
    #1;
    chk("passAddrA", 64'(addrOutA), 64'h155);
    chk("passDataA", 64'(dataOutA), 64'hDEADBEEF);
    chk("passWeA", 64'(weOutA), 64'hF);
    chk("passEnA", 64'(enOutA), 64'd1);
    chk("passBusyA", 64'(progBusyA), 64'd0);
    chk("passAddrB", 64'(addrOutB), 64'h1);
    tick();

    // one full word
    startSession();
    sendByte(8'h11, 0); sendByte(8'h22, 1); sendByte(8'h33, 0); sendByte(8'h44, 2);
    endSession();

    // six bytes then flush of the partial word
    startSession();
    for (int i = 1; i <= 6; i++) sendByte(8'(8'h11 * i), 0);
    endSession();
    addrIn = 10'h2AA; dataIn = 32'h12345678; weIn = 4'h5; enIn = 1'b1;
    #1;
    chk("afterFlushAddrA", 64'(addrOutA), 64'h2AA);
    chk("afterFlushDataA", 64'(dataOutA), 64'h12345678);
    tick();

    // strobe held high for 10 cycles counts once
    startSession();
    modelByte(8'hA5);
    progData = 8'hA5; progValid = 1'b1;
    repeat (10) tick();
    progValid = 1'b0;
    tick();
    checkCounters();
    sendByte(8'hB6, 0); sendByte(8'hC7, 1); sendByte(8'hD8, 0);
    endSession();

    // strobe already high when programming starts is ignored
    progData = 8'h5A; progValid = 1'b1;
    repeat (2) tick();
    startSession();
    repeat (3) tick();
    progValid = 1'b0;
    tick();
    checkCounters();
    sendByte(8'h01, 0); sendByte(8'h02, 0); sendByte(8'h03, 0); sendByte(8'h04, 0);
    endSession();

    // progEn falls on the completing byte: write, then done, no flush
    startSession();
    sendByte(8'hE1, 0); sendByte(8'hE2, 0); sendByte(8'hE3, 0);
    modelByte(8'hE4);
    progData = 8'hE4; progValid = 1'b1;
    tick();
    progValid = 1'b0; progEn = 1'b0;
    repeat (3) tick();
    doneExp++;
    chk("dropDoneA", 64'(doneA), 64'(doneExp));
    checkCounters();

    // wrap on the 2-bit instance
    startSession();
    for (int i = 0; i < 20; i++) sendByte(8'($urandom), 0);
    endSession();

    // reset mid-word, release with progEn high
    startSession();
    sendByte(8'h77, 0); sendByte(8'h88, 0);
    curBytes.delete();
    rstn = 1'b0;
    #2;
    chk("midRstAddrA", 64'(addrOutA), 64'd0);
    chk("midRstDataA", 64'(dataOutA), 64'd0);
    chk("midRstEnA", 64'(enOutA), 64'd0);
    chk("midRstWeA", 64'(weOutA), 64'd0);
    chk("midRstBusyA", 64'(progBusyA), 64'd0);
    chk("midRstCountA", 64'(wordCountA), 64'd0);
    chk("midRstDoneB", 64'(progDoneB), 64'd0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    sessWords = 0;
    checkCounters();
    sendByte(8'h9A, 0); sendByte(8'h9B, 0); sendByte(8'h9C, 0); sendByte(8'h9D, 0);
    endSession();

    // randomized sessions
    for (int s = 0; s < 8; s++) begin
      tick();
      startSession();
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) sendByte(8'($urandom), $urandom_range(0, 2));
      endSession();
    end

    repeat (2) tick();
    chk("pendingA", 64'(qA.size()), 64'd0);
    chk("pendingB", 64'(qB.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_word_loader.md
# prog_word_loader

Parametrised byte-to-word program loader sitting between the UART byte stream and the instruction/data memory port. While programming is enabled it packs incoming bytes into words of configurable width and byte order, then writes them to consecutive memory addresses. When the stream ends mid-word it flushes the partial word with byte-lane write enables. When programming is disabled it passes the CPU memory port through unchanged.

## Interface
- BYTES_PER_WORD, 4: bytes per memory word, ≥2; word width W = 8·BYTES_PER_WORD
- ADDR_W, 10: memory word-address width
- BIG_ENDIAN, 0: 0 = first byte to lane 0 (bits 7:0); 1 = first byte to the top lane
- clkMem  in  1  memory clock, rising edge
- rstn  in  1  asynchronous active-low reset
- progData  in  8  UART byte
- progValid  in  1  byte strobe (level); one byte accepted per rising edge
- progEn  in  1  programming mode request
- addrIn / dataIn / weIn / enIn  in  ADDR_W / W / BYTES_PER_WORD / 1  CPU memory port
- addrOut / dataOut / weOut / enOut  out  ADDR_W / W / BYTES_PER_WORD / 1  memory port
- progBusy  out  1  high while the programming path owns the memory port
- progDone  out  1  one-cycle pulse at the end of a programming session
- wordCount  out  ADDR_W+1  words written (full and partial) since the last session start
- overflow  out  1  sticky; set when the address counter wraps

## Operation
- Registers: progEnQ and validQ (previous-cycle samples), byteIdx, assembly register asm, write register wreg/wbe, wordAddr, state.
- Byte accept condition: progValid & !validQ & progEn & progEnQ. No byte is accepted in the first cycle after progEn rises.
- States:
  - IDLE: entered on reset.
  - COLLECT
  - WRITE: one cycle.
  - FLUSH: one cycle.
- IDLE → COLLECT on progEn & !progEnQ. On this transition, clear wordAddr, byteIdx, asm, wordCount and overflow.
- Accepted byte k (byteIdx) goes to lane k, or to lane BYTES_PER_WORD-1-k when BIG_ENDIAN=1.
- When the accepted byte completes a word:
  - wreg ← asm with the new byte merged in; wbe ← all ones.
  - byteIdx ← 0 and asm ← 0.
  - Next state is WRITE.
- Byte acceptance continues in every state except IDLE and FLUSH. A byte accepted in WRITE goes into the next word.
- WRITE drives addrOut=wordAddr, dataOut=wreg, weOut=wbe, enOut=1. It then increments wordAddr (modulo 2^ADDR_W; wrap sets overflow) and wordCount.
  - Next state: COLLECT if progEn is high.
  - Otherwise FLUSH if byteIdx≠0, else IDLE.
- COLLECT with progEn low:
  - byteIdx≠0 → FLUSH. Before entering, load wreg=asm and wbe=the lanes already filled; unfilled lanes are 0.
  - byteIdx=0 → IDLE.
- FLUSH performs one write exactly like WRITE, then goes to IDLE.
- Every transition into IDLE from COLLECT, WRITE or FLUSH pulses progDone.
- Port ownership:
  - State IDLE with progEn low: all outputs mirror the CPU inputs combinationally.
  - Otherwise progBusy=1 and the CPU inputs are ignored.
  - In non-write cycles of programming mode: enOut=0, weOut=0, addrOut=wordAddr, dataOut=wreg.
- Reset (rstn low, any state):
  - All registers are cleared and the state is IDLE. progBusy=0, progDone=0, wordCount=0, overflow=0.
  - Outputs mirror the CPU port when progEn=0; otherwise addrOut=0, dataOut=0, weOut=0, enOut=0.
  - Reset mid-word discards the partial word with no write. Release with progEn high starts a new session, because progEnQ resets to 0.

## Timing
- validQ and progEnQ sample on every clkMem edge.
- A byte sampled at edge t is stored in asm at edge t.
- The write for a completed word occurs in the cycle after the completing byte's accept, i.e. it is visible from edge t to edge t+1.
- Accepts are at least 2 cycles apart, because edge detection limits them to one byte per 2 cycles. A WRITE can therefore never collide with the next word's completion.
- progEn falling at the same edge that completes a word: WRITE, then IDLE with a progDone pulse; no FLUSH.
- A new session requires progEn low for at least one cycle.
- The partial write (FLUSH) occurs 1 cycle after progEn is sampled low.

## Test plan
- Pass-through: after reset with progEn=0, apply addrIn=0x155, dataIn=0xDEADBEEF, weIn=0xF, enIn=1 → outputs equal the inputs in the same cycle; progBusy=0.
- Full word, little endian: progEn=1, bytes 0x11, 0x22, 0x33, 0x44 with progValid toggling every 2 cycles → exactly one write cycle with addrOut=0, dataOut=0x44332211, weOut=0xF, enOut=1; wordCount=1. With BIG_ENDIAN=1, dataOut=0x11223344.
- Partial flush: 6 bytes 0x11…0x66 sent, then progEn dropped → full write to addr 0 (0x44332211, 0xF), then a flush write to addr 1 with dataOut=0x00006655 and weOut=0x3. progDone pulses once; wordCount=2; the port then mirrors the CPU inputs.
- Strobe edge detection: progValid held high for 10 cycles → a single byte is accepted. progValid already high when progEn rises → no byte is accepted until progValid goes low and then high again.
- Wrap: ADDR_W=2, send 5 full words → writes go to addresses 0, 1, 2, 3, 0; overflow=1 after the 4th write and stays set; wordCount=5.
- Reset mid-operation: assert rstn low after 2 bytes of a word → no write ever issued, all counters 0. Release with progEn high → new session starts at addr 0.
